// File: rtl/hdmi_pixel_fifo.sv
// First-word-fall-through pixel FIFO feeding the HDMI TMDS stage, with underflow fill colour and frame-start detect.
// Optional build macro HDMI_FIFO_RESYNC_EN: flush the FIFO in the frame_start cycle.
module hdmi_pixel_fifo #(
  parameter int unsigned DEPTH_LOG2    = 10,
  parameter int unsigned LOW_WATER     = 512,
  parameter logic [23:0] UNDERFLOW_RGB = 24'h0000FF
) (
  input  logic                  clock_pixel,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [23:0]           wr_rgb,
  input  logic                  pix_de,
  input  logic                  pix_vsync_n,
  output logic [7:0]            oRed,
  output logic [7:0]            oGreen,
  output logic [7:0]            oBlue,
  output logic                  fill_req,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow,
  input  logic                  clr_status,
  output logic                  frame_start
);

  localparam int unsigned          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  LOW_LVL  = (DEPTH_LOG2 + 1)'(LOW_WATER);
  localparam logic [DEPTH_LOG2:0]  LVL_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
  localparam logic [DEPTH_LOG2:0]  LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

  logic [23:0]           r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_run;
  logic                  r_underflow;
  logic                  r_vs_d;
  logic                  r_frame_start;

  logic                  w_flush;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_pop_empty;
  logic [23:0]           w_head;

`ifdef HDMI_FIFO_RESYNC_EN
  assign w_flush = r_frame_start;
`else
  assign w_flush = 1'b0;
`endif

  assign w_empty     = (r_level == LVL_ZERO);
  assign w_full      = (r_level == FULL_LVL);
  // r_run keeps the write side closed until the first edge after reset release.
  assign wr_ready    = r_run & ~w_full & ~w_flush;
  assign w_push      = wr_valid & wr_ready;
  assign w_pop       = pix_de & ~w_empty & ~w_flush;
  assign w_pop_empty = pix_de & w_empty;
  assign w_head      = (w_empty | w_flush) ? UNDERFLOW_RGB : r_mem[r_rd_ptr];

  assign {oRed, oGreen, oBlue} = w_head;
  assign fill_req    = (r_level <= LOW_LVL);
  assign level       = r_level;
  assign underflow   = r_underflow;
  assign frame_start = r_frame_start;

  // Pixel storage, written only on an accepted push.
  always_ff @(posedge clock_pixel) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_rgb;
    end
  end

  // Pointers and occupancy; a flush discards everything at once.
  always_ff @(posedge clock_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_level  <= LVL_ZERO;
    end else if (w_flush) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_level  <= LVL_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Status: write enable after reset, sticky underflow (set beats clear), vsync edge detect.
  always_ff @(posedge clock_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_run         <= 1'b0;
      r_underflow   <= 1'b0;
      r_vs_d        <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_vs_d        <= pix_vsync_n;
      r_frame_start <= r_vs_d & ~pix_vsync_n;
      if (w_pop_empty) begin
        r_underflow <= 1'b1;
      end else if (clr_status) begin
        r_underflow <= 1'b0;
      end else begin
        r_underflow <= r_underflow;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_pixel_fifo.sv
// Scoreboard bench for hdmi_pixel_fifo: accepted pushes queue expected pixels, a negedge monitor checks every DE pixel.
module tb_hdmi_pixel_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [23:0] wr_rgb = 24'h000000;
  logic        pix_de = 1'b0;
  logic        pix_vsync_n = 1'b1;
  logic [7:0]  o_r, o_g, o_b;
  logic        fill_req;
  logic [10:0] level;
  logic        underflow;
  logic        clr_status = 1'b0;
  logic        frame_start;

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [23:0] exp_q[$];
  logic        acc_exp = 1'b0;

  hdmi_pixel_fifo dut (
    .clock_pixel(clk), .reset_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rgb(wr_rgb), .pix_de(pix_de), .pix_vsync_n(pix_vsync_n),
    .oRed(o_r), .oGreen(o_g), .oBlue(o_b), .fill_req(fill_req), .level(level),
    .underflow(underflow), .clr_status(clr_status), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Commit edge: an accepted push becomes expected output from the next cycle on.
  task automatic tick();
    @(posedge clk);
    if (wr_valid && acc_exp) exp_q.push_back(wr_rgb);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [23:0] d, input logic acc, input logic de);
    wr_valid = v; wr_rgb = d; acc_exp = acc; pix_de = de;
    if (v) check("wr_ready", {31'd0, wr_ready}, {31'd0, acc});
    tick();
    wr_valid = 1'b0; pix_de = 1'b0; acc_exp = 1'b0;
  endtask

  // Monitor: every DE cycle consumes the head pixel or the underflow colour.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && pix_de) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'h0000FF;
      check("pixel", {8'd0, o_r, o_g, o_b}, {8'd0, e});
    end
  end

  initial begin
    #2;
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_fill_req", {31'd0, fill_req}, 32'd1);
    check("rst_level", {21'd0, level}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_rgb", {8'd0, o_r, o_g, o_b}, 32'h0000FF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("ready_at_release", {31'd0, wr_ready}, 32'd0);
    tick();
    check("ready_after_release", {31'd0, wr_ready}, 32'd1);

    // Four pushes then four pops in order.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 24'(i), 1'b1, 1'b0);
    check("level_4", {21'd0, level}, 32'd4);
    for (int i = 3; i >= 0; i--) begin
      cyc(1'b0, 24'h0, 1'b0, 1'b1);
      check("level_drain", {21'd0, level}, 32'(i));
    end

    // Underflow, hold, set-beats-clear, clear.
    cyc(1'b0, 24'h0, 1'b0, 1'b1);
    check("underflow_set", {31'd0, underflow}, 32'd1);
    cyc(1'b0, 24'h0, 1'b0, 1'b0);
    check("underflow_hold", {31'd0, underflow}, 32'd1);
    clr_status = 1'b1;
    cyc(1'b0, 24'h0, 1'b0, 1'b1);
    clr_status = 1'b0;
    check("underflow_set_wins", {31'd0, underflow}, 32'd1);
    clr_status = 1'b1;
    cyc(1'b0, 24'h0, 1'b0, 1'b0);
    clr_status = 1'b0;
    check("underflow_clr", {31'd0, underflow}, 32'd0);

    // Push and pop while empty: pop underflows, push lands.
    cyc(1'b1, 24'h0A0B0C, 1'b1, 1'b1);
    check("empty_pushpop_level", {21'd0, level}, 32'd1);
    check("empty_pushpop_uf", {31'd0, underflow}, 32'd1);
    clr_status = 1'b1;
    cyc(1'b0, 24'h0, 1'b0, 1'b1);
    clr_status = 1'b0;
    check("pop_after_uf_level", {21'd0, level}, 32'd0);
    check("no_uf_on_valid_pop", {31'd0, underflow}, 32'd0);

    // Fill to full; push+pop while full does not admit the push.
    for (int i = 0; i < 1024; i++) cyc(1'b1, 24'h200000 + 24'(i), 1'b1, 1'b0);
    check("full_level", {21'd0, level}, 32'd1024);
    check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("full_fill_req", {31'd0, fill_req}, 32'd0);
    cyc(1'b1, 24'hDEAD00, 1'b0, 1'b1);
    check("full_pushpop_level", {21'd0, level}, 32'd1023);
    for (int i = 0; i < 1023; i++) cyc(1'b0, 24'h0, 1'b0, 1'b1);
    check("full_drained", {21'd0, level}, 32'd0);

    // Low-water boundary.
    for (int i = 0; i < 513; i++) begin
      cyc(1'b1, 24'h600000 + 24'(i), 1'b1, 1'b0);
      if (i == 511) check("fill_req_512", {31'd0, fill_req}, 32'd1);
    end
    check("level_513", {21'd0, level}, 32'd513);
    check("fill_req_513", {31'd0, fill_req}, 32'd0);
    cyc(1'b0, 24'h0, 1'b0, 1'b1);
    check("level_512", {21'd0, level}, 32'd512);
    check("fill_req_back", {31'd0, fill_req}, 32'd1);
    for (int i = 0; i < 512; i++) cyc(1'b0, 24'h0, 1'b0, 1'b1);

    // 1100 interleaved push/pop across the pointer wrap.
    for (int i = 0; i < 1102; i++)
      cyc(i < 1100, 24'h100000 + 24'(i), i < 1100, i >= 2);
    check("wrap_level", {21'd0, level}, 32'd0);

    // Frame start with 300 words stored.
    for (int i = 0; i < 300; i++) cyc(1'b1, 24'h300000 + 24'(i), 1'b1, 1'b0);
    pix_vsync_n = 1'b0;
    cyc(1'b0, 24'h0, 1'b0, 1'b0);
    check("frame_start_pulse", {31'd0, frame_start}, 32'd1);
    check("frame_level_pre", {21'd0, level}, 32'd300);
`ifdef HDMI_FIFO_RESYNC_EN
    check("flush_rgb", {8'd0, o_r, o_g, o_b}, 32'h0000FF);
    cyc(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    check("flush_level", {21'd0, level}, 32'd0);
    check("frame_start_end", {31'd0, frame_start}, 32'd0);
    exp_q.delete();
    pix_vsync_n = 1'b1;
    cyc(1'b0, 24'h0, 1'b0, 1'b0);
`else
    cyc(1'b0, 24'h0, 1'b0, 1'b0);
    check("frame_level_kept", {21'd0, level}, 32'd300);
    check("frame_start_end", {31'd0, frame_start}, 32'd0);
    pix_vsync_n = 1'b1;
    for (int i = 0; i < 300; i++) cyc(1'b0, 24'h0, 1'b0, 1'b1);
    check("frame_drained", {21'd0, level}, 32'd0);
`endif
    check("no_pulse_on_rise", {31'd0, frame_start}, 32'd0);
    check("underflow_untouched", {31'd0, underflow}, 32'd0);

    // Reset mid-burst discards everything immediately.
    for (int i = 0; i < 5; i++) cyc(1'b1, 24'h400000 + 24'(i), 1'b1, 1'b0);
    wr_valid = 1'b1; wr_rgb = 24'h4FFFFF;
    rst_n = 1'b0;
    #1;
    check("midrst_level", {21'd0, level}, 32'd0);
    check("midrst_ready", {31'd0, wr_ready}, 32'd0);
    check("midrst_rgb", {8'd0, o_r, o_g, o_b}, 32'h0000FF);
    wr_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    cyc(1'b1, 24'h500001, 1'b1, 1'b0);
    check("post_rst_level", {21'd0, level}, 32'd1);
    cyc(1'b0, 24'h0, 1'b0, 1'b1);
    check("post_rst_drain", {21'd0, level}, 32'd0);
    check("post_rst_uf", {31'd0, underflow}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
